// File: rtl/breg_context_switch_ctrl.sv
// Context switch sequencer for the program half of the register bank.
// Saves program registers into a per-process save area in data memory,
// restores them from another process's area, or does both back to back.
// The CPU is expected to stall on busy while a sequence is running.
module breg_context_switch_ctrl #(
   parameter int NUM_REGS = 32,
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32,
   parameter int PID_W    = 4,
   localparam int IDX_W   = $clog2(NUM_REGS)
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [PID_W-1:0]  pid_old,
   input  logic [PID_W-1:0]  pid_new,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              busy,
   output logic              done,
   output logic              rf_bank,
   output logic [IDX_W-1:0]  rf_addr,
   input  logic [DATA_W-1:0] rf_rdata,
   output logic              rf_write,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   localparam logic [1:0] OP_NOP     = 2'b00;
   localparam logic [1:0] OP_RESTORE = 2'b10;
   localparam logic [1:0] OP_SWITCH  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SAVE,
      ST_LOAD,
      ST_WRITE,
      ST_DONE
   } state_t;

   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic [1:0]         op_q;
   logic [PID_W-1:0]   pid_old_q;
   logic [PID_W-1:0]   pid_new_q;
   logic [ADDR_W-1:0]  base_q;
   logic               last_idx;
   logic [IDX_W-1:0]   idx_next;

   // Word address of one register slot inside a process save area; wraps naturally.
   function automatic logic [ADDR_W-1:0] slot_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [PID_W-1:0]  pid,
                                                  input logic [IDX_W-1:0]  i);
      return base + ADDR_W'(pid) * ADDR_W'(NUM_REGS) + ADDR_W'(i);
   endfunction

   assign last_idx  = (idx == IDX_W'(NUM_REGS - 1));
   assign idx_next  = idx + IDX_W'(1);
   assign rf_bank   = 1'b1;
   assign rf_addr   = idx;
   assign mem_wdata = rf_rdata;

   // Single sequencing FSM; every control output is registered alongside the state.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         idx       <= '0;
         op_q      <= '0;
         pid_old_q <= '0;
         pid_new_q <= '0;
         base_q    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         rf_write  <= 1'b0;
         rf_wdata  <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start && op != OP_NOP) begin
                  op_q      <= op;
                  pid_old_q <= pid_old;
                  pid_new_q <= pid_new;
                  base_q    <= base_addr;
                  idx       <= '0;
                  busy      <= 1'b1;
                  mem_req   <= 1'b1;
                  if (op == OP_RESTORE) begin
                     state    <= ST_LOAD;
                     mem_we   <= 1'b0;
                     mem_addr <= slot_addr(base_addr, pid_new, '0);
                  end else begin
                     state    <= ST_SAVE;
                     mem_we   <= 1'b1;
                     mem_addr <= slot_addr(base_addr, pid_old, '0);
                  end
               end
            end
            ST_SAVE: begin
               if (mem_ack) begin
                  if (!last_idx) begin
                     idx      <= idx_next;
                     mem_addr <= slot_addr(base_q, pid_old_q, idx_next);
                  end else if (op_q == OP_SWITCH) begin
                     idx      <= '0;
                     mem_we   <= 1'b0;
                     mem_addr <= slot_addr(base_q, pid_new_q, '0);
                     state    <= ST_LOAD;
                  end else begin
                     mem_req  <= 1'b0;
                     mem_we   <= 1'b0;
                     done     <= 1'b1;
                     state    <= ST_DONE;
                  end
               end
            end
            ST_LOAD: begin
               if (mem_ack) begin
                  rf_wdata <= mem_rdata;
                  mem_req  <= 1'b0;
                  rf_write <= 1'b1;
                  state    <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               rf_write <= 1'b0;
               if (last_idx) begin
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  idx      <= idx_next;
                  mem_req  <= 1'b1;
                  mem_addr <= slot_addr(base_q, pid_new_q, idx_next);
                  state    <= ST_LOAD;
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_breg_context_switch_ctrl.sv
// Scoreboard bench for breg_context_switch_ctrl: a reference model of the
// save/restore rules queues expected memory writes, register writes and done
// pulses; a monitor pops and compares them as the DUT produces them.
module tb_breg_context_switch_ctrl;

   localparam int NUM_REGS = 32;
   localparam int K_MW     = 0;
   localparam int K_RW     = 1;
   localparam int K_DONE   = 2;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        start;
   logic [1:0]  op;
   logic [3:0]  pid_old;
   logic [3:0]  pid_new;
   logic [31:0] base_addr;
   logic        busy;
   logic        done;
   logic        rf_bank;
   logic [4:0]  rf_addr;
   logic [31:0] rf_rdata;
   logic        rf_write;
   logic [31:0] rf_wdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [31:0] data;
      bit          chk_lat;
   } item_t;

   item_t       sbq[$];
   logic [31:0] regs     [NUM_REGS];
   logic [31:0] exp_regs [NUM_REGS];
   logic [31:0] mem      [logic [31:0]];
   logic [31:0] exp_mem  [logic [31:0]];

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int start_cyc   = 0;
   int writes_seen = 0;
   int ack_lat     = 0;
   int wait_cnt    = 0;
   bit ack_noise   = 1'b0;
   bit active      = 1'b0;
   bit prev_pending = 1'b0;
   logic [31:0] prev_addr = '0;
   logic        prev_we   = 1'b0;

   breg_context_switch_ctrl dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (start),
      .op        (op),
      .pid_old   (pid_old),
      .pid_new   (pid_new),
      .base_addr (base_addr),
      .busy      (busy),
      .done      (done),
      .rf_bank   (rf_bank),
      .rf_addr   (rf_addr),
      .rf_rdata  (rf_rdata),
      .rf_write  (rf_write),
      .rf_wdata  (rf_wdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   always #5 clock = ~clock;

   // Cycle counter used to measure start-to-done latency.
   always @(posedge clock) cyc <= cyc + 1;

   assign rf_rdata = regs[rf_addr];

   function automatic logic [31:0] fill_word(input logic [31:0] a);
      return a ^ 32'hC3C3_0000;
   endfunction

   function automatic logic [31:0] env_read(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return fill_word(a);
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      if (exp_mem.exists(a)) return exp_mem[a];
      return fill_word(a);
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic expect_item(input int k, input logic [31:0] a, input logic [31:0] d);
      item_t e;
      if (sbq.size() == 0) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL unexpected_output: got kind %0d addr 0x%0h data 0x%0h, expected nothing", k, a, d);
         return;
      end
      e = sbq.pop_front();
      checkOutput("output_kind", 64'(k), 64'(e.kind));
      if (k == e.kind) begin
         if (k == K_MW) begin
            checkOutput("mem_write_addr", 64'(a), 64'(e.addr));
            checkOutput("mem_write_data", 64'(d), 64'(e.data));
         end else if (k == K_RW) begin
            checkOutput("rf_write_addr", 64'(a), 64'(e.addr));
            checkOutput("rf_write_data", 64'(d), 64'(e.data));
         end else if (e.chk_lat) begin
            checkOutput("done_latency", 64'(a), 64'(e.addr));
         end
      end
   endtask

   // Reference model: a save copies every register into the slot table, a restore copies it back.
   task automatic model_save(input logic [3:0] pid, input logic [31:0] base);
      logic [31:0] a;
      for (int i = 0; i < NUM_REGS; i++) begin
         a = base + 32'(pid) * 32'(NUM_REGS) + 32'(i);
         sbq.push_back('{K_MW, a, exp_regs[i], 1'b0});
         exp_mem[a] = exp_regs[i];
      end
   endtask

   task automatic model_restore(input logic [3:0] pid, input logic [31:0] base);
      logic [31:0] a;
      logic [31:0] d;
      for (int i = 0; i < NUM_REGS; i++) begin
         a = base + 32'(pid) * 32'(NUM_REGS) + 32'(i);
         d = model_read(a);
         sbq.push_back('{K_RW, 32'(i), d, 1'b0});
         exp_regs[i] = d;
      end
   endtask

   // Issue one request, queue its expected effects, and wait (bounded) for it to finish.
   task automatic applyStimulus(input logic [1:0] o, input logic [3:0] po, input logic [3:0] pn,
                                input logic [31:0] base, input bit inject);
      int lat;
      for (int n = 0; n < 1000 && active; n++) @(negedge clock);
      @(negedge clock);
      op        = o;
      pid_old   = po;
      pid_new   = pn;
      base_addr = base;
      start     = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      if (o == 2'b00) begin
         repeat (4) @(negedge clock);
         return;
      end
      if (o[0]) model_save(po, base);
      if (o[1]) model_restore(pn, base);
      lat = 1 + (o[0] ? 32 : 0) + (o[1] ? 64 : 0);
      sbq.push_back('{K_DONE, 32'(lat), 32'd0, (ack_lat == 0)});
      start_cyc = cyc;
      active    = 1'b1;
      for (int n = 0; n < 5000 && active; n++) begin
         @(negedge clock);
         if (inject && active && $urandom_range(0, 5) == 0) begin
            op        = 2'($urandom);
            pid_old   = 4'($urandom);
            pid_new   = 4'($urandom);
            base_addr = $urandom;
            start     = 1'b1;
            @(posedge clock);
            #1;
            start = 1'b0;
         end
      end
      if (active) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL done_timeout: got no done, expected done within 5000 cycles");
         sbq.delete();
         active = 1'b0;
      end
   endtask

   // Memory responder: ack after ack_lat waiting cycles (0 = ack tied high), optional stray acks.
   always @(negedge clock) begin
      if (ack_lat == 0) begin
         mem_ack = 1'b1;
      end else if (mem_ack) begin
         mem_ack  = 1'b0;
         wait_cnt = 0;
      end else if (mem_req) begin
         wait_cnt++;
         if (wait_cnt >= ack_lat) mem_ack = 1'b1;
      end else begin
         mem_ack = ack_noise && ($urandom_range(0, 3) == 0);
      end
      mem_rdata = env_read(mem_addr);
   end

   // Monitor: records transfers that complete on the coming edge and checks protocol rules.
   always @(negedge clock) begin
      #1;
      if (reset_n) begin
         checkOutput("busy", 64'(busy), 64'(active));
         checkOutput("rf_bank", 64'(rf_bank), 64'(1));
         if (prev_pending) begin
            checkOutput("req_held", 64'(mem_req), 64'(1));
            checkOutput("addr_stable", 64'(mem_addr), 64'(prev_addr));
            checkOutput("we_stable", 64'(mem_we), 64'(prev_we));
         end
         if (mem_we) checkOutput("we_with_req", 64'(mem_req), 64'(1));
         if (rf_write) checkOutput("no_req_in_write", 64'(mem_req), 64'(0));
         prev_pending = mem_req && !mem_ack;
         prev_addr    = mem_addr;
         prev_we      = mem_we;
         if (mem_req && mem_ack && mem_we) begin
            mem[mem_addr] = mem_wdata;
            writes_seen++;
            expect_item(K_MW, mem_addr, mem_wdata);
         end
         if (rf_write) begin
            regs[rf_addr] = rf_wdata;
            expect_item(K_RW, 32'(rf_addr), rf_wdata);
         end
         if (done) begin
            expect_item(K_DONE, 32'(cyc - start_cyc + 1), 32'd0);
            active = 1'b0;
         end
      end else begin
         prev_pending = 1'b0;
      end
   end

   task automatic check_all_zero(input string tag);
      checkOutput({tag, "_ctrl"}, 64'({busy, done, rf_write, mem_req, mem_we}), 64'(0));
      checkOutput({tag, "_rf_addr"}, 64'(rf_addr), 64'(0));
      checkOutput({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
      checkOutput({tag, "_rf_wdata"}, 64'(rf_wdata), 64'(0));
   endtask

   initial begin
      logic [31:0] v;
      reset_n   = 1'b0;
      start     = 1'b0;
      op        = 2'b00;
      pid_old   = '0;
      pid_new   = '0;
      base_addr = '0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         v           = $urandom;
         regs[i]     = v;
         exp_regs[i] = v;
      end

      repeat (3) @(posedge clock);
      #1;
      check_all_zero("reset");
      @(negedge clock);
      reset_n = 1'b1;

      $display("[TB] save pid 2 at base 0x100, ack tied high");
      ack_lat = 0;
      applyStimulus(2'b01, 4'd2, 4'd0, 32'h100, 1'b0);

      $display("[TB] restore pid 3 from preloaded area");
      for (int i = 0; i < NUM_REGS; i++) begin
         mem[32'h160 + 32'(i)]     = 32'hA000 + 32'(i);
         exp_mem[32'h160 + 32'(i)] = 32'hA000 + 32'(i);
      end
      applyStimulus(2'b10, 4'd0, 4'd3, 32'h100, 1'b0);

      $display("[TB] switch with 3-cycle ack latency");
      ack_lat = 3;
      applyStimulus(2'b11, 4'd5, 4'd7, 32'h2000, 1'b0);

      $display("[TB] start pulses while busy, op 00 while idle");
      ack_lat   = 1;
      ack_noise = 1'b1;
      applyStimulus(2'b11, 4'd1, 4'd2, 32'h4000, 1'b1);
      applyStimulus(2'b00, 4'd3, 4'd3, 32'h4000, 1'b0);
      ack_noise = 1'b0;

      $display("[TB] reset in the middle of a save");
      ack_lat = 0;
      @(negedge clock);
      writes_seen = 0;
      op          = 2'b01;
      pid_old     = 4'd4;
      base_addr   = 32'h300;
      start       = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      model_save(4'd4, 32'h300);
      sbq.push_back('{K_DONE, 32'd33, 32'd0, 1'b1});
      start_cyc = cyc;
      active    = 1'b1;
      repeat (10) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      checkOutput("abort_idx", 64'(rf_addr), 64'(10));
      checkOutput("abort_writes", 64'(writes_seen), 64'(10));
      @(posedge clock);
      #1;
      sbq.delete();
      active = 1'b0;
      check_all_zero("abort");
      @(negedge clock);
      reset_n = 1'b1;
      applyStimulus(2'b01, 4'd4, 4'd0, 32'h300, 1'b0);

      $display("[TB] save and restore across address wrap");
      applyStimulus(2'b01, 4'd0, 4'd0, 32'hFFFF_FFF0, 1'b0);
      applyStimulus(2'b10, 4'd0, 4'd0, 32'hFFFF_FFF0, 1'b0);

      $display("[TB] random requests");
      for (int t = 0; t < 10; t++) begin
         ack_lat   = $urandom_range(0, 3);
         ack_noise = 1'($urandom_range(0, 1));
         applyStimulus(2'($urandom), 4'($urandom), 4'($urandom),
                       ($urandom_range(0, 2) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255))) : $urandom,
                       1'($urandom_range(0, 1)));
      end

      repeat (4) @(negedge clock);
      for (int i = 0; i < NUM_REGS; i++) checkOutput("final_reg", 64'(regs[i]), 64'(exp_regs[i]));
      checkOutput("leftover_items", 64'(sbq.size()), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
